// File: rtl/rv32i_mem_pkg.sv
// Shared RV32I data-memory definitions: access widths, responder FSM states,
// and the lane-enable / load-extract helpers also used by the load/store stage.
package rv32i_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  // Illegal width or an offset that does not match the access size.
  function automatic logic mem_bad_access(input logic [1:0] width, input logic [1:0] a);
    logic bad;
    case (width)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = a[0];
      MEM_WORD: bad = (a != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched by an access of the given width at offset a.
  function automatic logic [3:0] mem_lane_en(input logic [1:0] width, input logic [1:0] a);
    logic [3:0] en;
    case (width)
      MEM_BYTE: en = 4'b0001 << a;
      MEM_HALF: en = 4'b0011 << a;
      MEM_WORD: en = 4'b1111;
      default:  en = 4'b0000;
    endcase
    return en;
  endfunction

  // Align the addressed bytes down to bit 0 and zero/sign-extend.
  function automatic logic [31:0] mem_load_extract(input logic [31:0] rdata,
                                                   input logic [1:0]  a,
                                                   input logic [1:0]  width,
                                                   input logic        sign);
    logic [31:0] raw;
    logic [31:0] res;
    raw = rdata >> {a, 3'b000};
    case (width)
      MEM_BYTE: res = {sign ? {24{raw[7]}}  : 24'b0, raw[7:0]};
      MEM_HALF: res = {sign ? {16{raw[15]}} : 16'b0, raw[15:0]};
      default:  res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32i_byte_lane_ram.sv
// Four byte-wide synchronous RAM lanes sharing one address; per-lane write
// enable and a registered 32-bit read. Contents are never reset.
module rv32i_byte_lane_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_q;
    logic [7:0] rd_d;

    // Read register captures only when asked, so it holds through a stalled response.
    always_comb begin
      rd_d = rd_q;
      if (rd_en) rd_d = mem[addr];
    end

    // Lane write plus read register (read-before-write on the same edge).
    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[8*l +: 8];
      rd_q <= rd_d;
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// RV32I data-memory responder: one load/store at a time, IDLE -> ACCESS -> RESP.
// Optional macro RV32I_DMEM_RANGE_CHECK_EN flags addresses beyond the RAM as errors;
// without it, upper address bits are ignored and addresses alias into the RAM.
module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        width_q, width_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              unused_upper;

  assign unused_upper = ^req_addr[31:ADDR_W+2];

  // Error classification of the incoming request.
  always_comb begin
    req_err = mem_bad_access(req_width, req_addr[1:0]);
`ifdef RV32I_DMEM_RANGE_CHECK_EN
    if (|req_addr[31:ADDR_W+2]) req_err = 1'b1;
`endif
  end

  // Next-state and request capture; req_* only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    width_d = width_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_W+1:0];
          width_d = req_width;
          sign_d  = req_sign;
          wdata_d = req_wdata;
          err_d   = req_err;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      width_q <= MEM_BYTE;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      sign_q  <= sign_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobes only in ACCESS for a good store; reset on that edge cancels it.
  always_comb begin
    ram_we    = 4'b0000;
    ram_wdata = wdata_q << {addr_q[1:0], 3'b000};
    if (state_q == ST_ACCESS && we_q && !err_q && !reset)
      ram_we = mem_lane_en(width_q, addr_q[1:0]);
  end

  rv32i_byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (addr_q[ADDR_W+1:2]),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rd_en (state_q == ST_ACCESS),
    .rdata (ram_rdata)
  );

  // Response outputs; data is zero for stores, errors and outside RESP.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !reset;
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = '0;
    if (rsp_valid && !we_q && !err_q)
      rsp_rdata = mem_load_extract(ram_rdata, addr_q[1:0], width_q, sign_q);
  end

endmodule
